vidac_blit: RTL and testbench

Parametrised successor to the single-mode VIDAC rectangle fill. Reads a command block from video memory, then fills, copies, or copies-with-colour-key a rectangle of 8-bit pixels in a selectable page. Shares the single-port video memory interface (a/i/o/w) with the same read-latency contract. Adds start/busy/done handshake, abort, clipping and error reporting.

---
 rtl/vidac_blit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_vidac_blit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vidac_blit.sv
// vidac_blit: rectangle blitter for 8-bit pixel video memory.
//
// The blitter reads a 14-byte command block from CMD_BASE and then fills,
// copies, or colour-key copies a rectangle in the selected page. It shares a
// single-port memory whose read data is valid READ_LAT cycles after the
// address settles. Destination pixels that fall off-screen are skipped, but
// their cycles still elapse.
//
// Ports
//   clock    system clock, all state changes on the rising edge
//   reset_n  asynchronous active-low reset
//   start    begin a command (accepted only when idle and abort is low)
//   abort    cancel the running command; no done pulse is produced
//   page     page select for source and destination, sampled at start
//   a        memory address
//   i        memory read data
//   o        memory write data
//   w        memory write strobe, one byte per high cycle
//   busy     high from the cycle after start until the done cycle inclusive
//   done     one-cycle completion pulse
//   err      sticky unknown-opcode flag, cleared by the next accepted start
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start
// S_FETCH  | reading command bytes 0..13, READ_LAT+1 cycles each
// S_DECODE | classify opcode, set up row bases and first pixel
// S_FILL   | one destination pixel per cycle
// S_SRC_RD | hold source address READ_LAT+1 cycles, capture pixel
// S_DST_WR | write captured pixel (suppressed on clip or key match)
// S_DONE   | done pulse, busy still high

module vidac_blit #(
  parameter int unsigned   AW         = 18,
  parameter int unsigned   SCREEN_W   = 320,
  parameter int unsigned   SCREEN_H   = 200,
  parameter int unsigned   PAGE_SHIFT = 16,
  parameter logic [AW-1:0] CMD_BASE   = 18'h20000,
  parameter int unsigned   READ_LAT   = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          page,
  output logic [AW-1:0] a,
  input  logic [7:0]    i,
  output logic [7:0]    o,
  output logic          w,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_FILL   = 3'd3,
    S_SRC_RD = 3'd4,
    S_DST_WR = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_FILL    = 8'h06;
  localparam logic [7:0] OP_COPY    = 8'h07;
  localparam logic [7:0] OP_KEYCOPY = 8'h08;
  localparam logic [2:0] RL_CNT     = 3'(READ_LAT);

  state_t        state_q;
  logic [3:0]    byte_idx_q;
  logic [2:0]    rd_cnt_q;
  logic          page_q;
  logic [7:0]    op_q, color_q;
  logic [15:0]   x_q, y_q, wd_q, ht_q, sx_q, sy_q;
  logic [15:0]   col_q, row_q;
  logic [AW-1:0] drow_q, srow_q;
  logic [AW-1:0] a_q;
  logic [7:0]    o_q;
  logic          w_q, busy_q, done_q, err_q;

  // Row bases are computed once at decode; afterwards they advance by
  // SCREEN_W per row so the pixel loop needs only adders.
  logic [AW-1:0] page_base, dec_drow, dec_srow, dec_dst_a, dec_src_a;
  logic          dec_vis, op_known, size_nz;
  assign page_base = AW'(page_q) << PAGE_SHIFT;
  assign dec_drow  = page_base + AW'(y_q) * AW'(SCREEN_W);
  assign dec_srow  = page_base + AW'(sy_q) * AW'(SCREEN_W);
  assign dec_dst_a = dec_drow + AW'(x_q);
  assign dec_src_a = dec_srow + AW'(sx_q);
  assign dec_vis   = (x_q < 16'(SCREEN_W)) && (y_q < 16'(SCREEN_H));
  assign op_known  = (op_q == OP_NOP) || (op_q == OP_FILL) ||
                     (op_q == OP_COPY) || (op_q == OP_KEYCOPY);
  assign size_nz   = (wd_q != 16'd0) && (ht_q != 16'd0);

  // Current pixel
  logic [15:0]   cur_px, cur_py;
  logic [AW-1:0] cur_dst_a;
  logic          cur_vis, key_hit;
  assign cur_px    = x_q + col_q;
  assign cur_py    = y_q + row_q;
  assign cur_dst_a = drow_q + AW'(x_q) + AW'(col_q);
  assign cur_vis   = (cur_px < 16'(SCREEN_W)) && (cur_py < 16'(SCREEN_H));
  assign key_hit   = (op_q == OP_KEYCOPY) && (i == color_q);

  // Next pixel in row-major order
  logic          last_col, last_row;
  logic [15:0]   nx_col, nx_row, nx_px, nx_py;
  logic [AW-1:0] nx_drow, nx_srow, nx_dst_a, nx_src_a;
  logic          nx_vis;
  assign last_col = (col_q == wd_q - 16'd1);
  assign last_row = (row_q == ht_q - 16'd1);
  assign nx_col   = last_col ? 16'd0 : col_q + 16'd1;
  assign nx_row   = last_col ? row_q + 16'd1 : row_q;
  assign nx_drow  = last_col ? drow_q + AW'(SCREEN_W) : drow_q;
  assign nx_srow  = last_col ? srow_q + AW'(SCREEN_W) : srow_q;
  assign nx_px    = x_q + nx_col;
  assign nx_py    = y_q + nx_row;
  assign nx_dst_a = nx_drow + AW'(x_q) + AW'(nx_col);
  assign nx_src_a = nx_srow + AW'(sx_q) + AW'(nx_col);
  assign nx_vis   = (nx_px < 16'(SCREEN_W)) && (nx_py < 16'(SCREEN_H));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 4'd0;
      rd_cnt_q   <= 3'd0;
      page_q     <= 1'b0;
      op_q       <= 8'd0;
      color_q    <= 8'd0;
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      wd_q       <= 16'd0;
      ht_q       <= 16'd0;
      sx_q       <= 16'd0;
      sy_q       <= 16'd0;
      col_q      <= 16'd0;
      row_q      <= 16'd0;
      drow_q     <= '0;
      srow_q     <= '0;
      a_q        <= '0;
      o_q        <= 8'd0;
      w_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q <= S_IDLE;
      w_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q    <= S_FETCH;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            page_q     <= page;
            a_q        <= CMD_BASE;
            byte_idx_q <= 4'd0;
            rd_cnt_q   <= RL_CNT;
          end
        end
        S_FETCH: begin
          if (rd_cnt_q != 3'd0) begin
            rd_cnt_q <= rd_cnt_q - 3'd1;
          end else begin
            case (byte_idx_q)
              4'd0:  op_q        <= i;
              4'd1:  x_q[7:0]    <= i;
              4'd2:  x_q[15:8]   <= i;
              4'd3:  y_q[7:0]    <= i;
              4'd4:  y_q[15:8]   <= i;
              4'd5:  wd_q[7:0]   <= i;
              4'd6:  wd_q[15:8]  <= i;
              4'd7:  ht_q[7:0]   <= i;
              4'd8:  ht_q[15:8]  <= i;
              4'd9:  color_q     <= i;
              4'd10: sx_q[7:0]   <= i;
              4'd11: sx_q[15:8]  <= i;
              4'd12: sy_q[7:0]   <= i;
              4'd13: sy_q[15:8]  <= i;
              default: ;
            endcase
            if (byte_idx_q == 4'd13) begin
              state_q <= S_DECODE;
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
              a_q        <= a_q + AW'(1);
              rd_cnt_q   <= RL_CNT;
            end
          end
        end
        S_DECODE: begin
          col_q  <= 16'd0;
          row_q  <= 16'd0;
          drow_q <= dec_drow;
          srow_q <= dec_srow;
          if (!op_known) err_q <= 1'b1;
          if ((op_q == OP_FILL) && size_nz) begin
            state_q <= S_FILL;
            a_q     <= dec_dst_a;
            o_q     <= color_q;
            w_q     <= dec_vis;
          end else if (((op_q == OP_COPY) || (op_q == OP_KEYCOPY)) && size_nz) begin
            state_q  <= S_SRC_RD;
            a_q      <= dec_src_a;
            rd_cnt_q <= RL_CNT;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_FILL: begin
          if (last_col && last_row) begin
            state_q <= S_DONE;
            w_q     <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            col_q  <= nx_col;
            row_q  <= nx_row;
            drow_q <= nx_drow;
            srow_q <= nx_srow;
            a_q    <= nx_dst_a;
            w_q    <= nx_vis;
          end
        end
        S_SRC_RD: begin
          if (rd_cnt_q != 3'd0) begin
            rd_cnt_q <= rd_cnt_q - 3'd1;
          end else begin
            state_q <= S_DST_WR;
            a_q     <= cur_dst_a;
            o_q     <= i;
            w_q     <= cur_vis && !key_hit;
          end
        end
        S_DST_WR: begin
          w_q <= 1'b0;
          if (last_col && last_row) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q  <= S_SRC_RD;
            col_q    <= nx_col;
            row_q    <= nx_row;
            drow_q   <= nx_drow;
            srow_q   <= nx_srow;
            a_q      <= nx_src_a;
            rd_cnt_q <= RL_CNT;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a    = a_q;
  assign o    = o_q;
  // Abort kills the strobe in the very cycle it is raised.
  assign w    = w_q & ~abort;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_vidac_blit.sv
// Self-checking bench for vidac_blit: a command table run through a
// scoreboard of expected memory writes, plus hand-written abort and reset
// sequences.
`timescale 1ns/1ps
module tb_vidac_blit;
  localparam int AW = 18;
  localparam logic [AW-1:0] CMD_BASE = 18'h20000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          page = 1'b0;
  logic [AW-1:0] a;
  logic [7:0]    i_q = 8'd0;
  logic [7:0]    o;
  logic          w, busy, done, err;

  vidac_blit dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .page(page), .a(a), .i(i_q), .o(o), .w(w), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Memory with READ_LAT=2: data in cycle c comes from the address of c-2.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] a_d1 = '0;
  always @(posedge clock) begin
    a_d1 <= a;
    i_q  <= mem[a_d1];
  end

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [15:0] x, y, wd, ht;
    logic [7:0]  color;
    logic [15:0] sx, sy;
    logic        pg;
    int          exp_wr;
    int          exp_busy;
    logic        exp_err;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_cmd(input vec_t v);
    logic [7:0] blk [14];
    blk[0] = v.op;        blk[1] = v.x[7:0];   blk[2] = v.x[15:8];
    blk[3] = v.y[7:0];    blk[4] = v.y[15:8];  blk[5] = v.wd[7:0];
    blk[6] = v.wd[15:8];  blk[7] = v.ht[7:0];  blk[8] = v.ht[15:8];
    blk[9] = v.color;     blk[10] = v.sx[7:0]; blk[11] = v.sx[15:8];
    blk[12] = v.sy[7:0];  blk[13] = v.sy[15:8];
    for (int k = 0; k < 14; k++) mem[CMD_BASE + AW'(k)] = blk[k];
  endtask

  task automatic run_vec(input vec_t v);
    logic [AW-1:0] ea_q[$];
    logic [7:0]    ed_q[$];
    int nb, nd, nw, da, sa, px, py;
    bit fin;
    load_cmd(v);
    if (v.op == 8'h06 || v.op == 8'h07 || v.op == 8'h08) begin
      for (int r = 0; r < int'(v.ht); r++) begin
        for (int c = 0; c < int'(v.wd); c++) begin
          px = (int'(v.x) + c) % 65536;
          py = (int'(v.y) + r) % 65536;
          da = int'(v.pg) * 65536 + (int'(v.y) + r) * 320 + int'(v.x) + c;
          sa = int'(v.pg) * 65536 + (int'(v.sy) + r) * 320 + int'(v.sx) + c;
          if (px < 320 && py < 200) begin
            if (v.op == 8'h06) begin
              ea_q.push_back(AW'(da)); ed_q.push_back(v.color);
            end else if (!(v.op == 8'h08 && mem[AW'(sa)] == v.color)) begin
              ea_q.push_back(AW'(da)); ed_q.push_back(mem[AW'(sa)]);
            end
          end
        end
      end
    end
    page = v.pg;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    nb = 0; nd = 0; nw = 0; fin = 1'b0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      if (busy) nb++;
      if (done) nd++;
      if (w) begin
        nw++;
        if (ea_q.size() == 0) begin
          chk({v.name, "_unexpected_write_addr"}, a, '1);
        end else begin
          chk({v.name, "_wr_addr"}, a, ea_q.pop_front());
          chk({v.name, "_wr_data"}, o, ed_q.pop_front());
        end
        mem[a] = o;
      end
      if (!busy) fin = 1'b1;
      else @(negedge clock);
    end
    chk({v.name, "_finished_in_budget"}, fin, 1'b1);
    chk({v.name, "_busy_cycles"}, nb, v.exp_busy);
    chk({v.name, "_done_pulses"}, nd, 1);
    chk({v.name, "_write_count"}, nw, v.exp_wr);
    chk({v.name, "_writes_missing"}, ea_q.size(), 0);
    chk({v.name, "_err"}, err, v.exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [9];
    vec_t abv;
    int cyc, nw, nd, first_w;

    for (int k = 0; k < (1 << AW); k++) mem[k] = 8'h00;
    mem[18'h10000] = 8'h11; mem[18'h10001] = 8'h22;
    mem[18'h10140] = 8'h33; mem[18'h10141] = 8'h44;

    //        name      op     x        y        wd      ht      color  sx     sy     pg  wr busy err
    vt[0] = '{"fill",   8'h06, 16'd160, 16'd100, 16'd4, 16'd3, 8'hAA, 16'd0, 16'd0, 1'b0, 12, 56, 1'b0};
    vt[1] = '{"copy",   8'h07, 16'h10,  16'd5,   16'd2, 16'd2, 8'h00, 16'd0, 16'd0, 1'b1,  4, 60, 1'b0};
    vt[2] = '{"keycp",  8'h08, 16'h10,  16'd5,   16'd2, 16'd2, 8'h22, 16'd0, 16'd0, 1'b1,  3, 60, 1'b0};
    vt[3] = '{"clipx",  8'h06, 16'd318, 16'd0,   16'd4, 16'd1, 8'h5A, 16'd0, 16'd0, 1'b0,  2, 48, 1'b0};
    vt[4] = '{"clipy",  8'h06, 16'd5,   16'd199, 16'd1, 16'd2, 8'h66, 16'd0, 16'd0, 1'b0,  1, 46, 1'b0};
    vt[5] = '{"wd0",    8'h06, 16'd0,   16'd0,   16'd0, 16'd5, 8'h99, 16'd0, 16'd0, 1'b0,  0, 44, 1'b0};
    vt[6] = '{"nop",    8'h00, 16'd0,   16'd0,   16'd2, 16'd2, 8'h99, 16'd0, 16'd0, 1'b0,  0, 44, 1'b0};
    vt[7] = '{"badop",  8'h3F, 16'd0,   16'd0,   16'd2, 16'd2, 8'h99, 16'd0, 16'd0, 1'b0,  0, 44, 1'b1};
    vt[8] = '{"clrerr", 8'h06, 16'd1,   16'd199, 16'd1, 16'd1, 8'h77, 16'd0, 16'd0, 1'b0,  1, 45, 1'b0};

    repeat (3) @(negedge clock);
    chk("reset_a", a, 0);
    chk("reset_o", o, 0);
    chk("reset_w", w, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int n = 0; n < 9; n++) run_vec(vt[n]);

    chk("mem_7DA0", mem[18'h07DA0], 8'hAA);
    chk("mem_8023", mem[18'h08023], 8'hAA);
    chk("mem_10650", mem[18'h10650], 8'h11);
    chk("mem_10791", mem[18'h10791], 8'h44);
    chk("mem_013F", mem[18'h0013F], 8'h5A);
    chk("mem_013D_untouched", mem[18'h0013D], 8'h00);

    // Abort on the third fill pixel; an extra start during fetch is ignored.
    abv = '{"abort", 8'h06, 16'd0, 16'd10, 16'd8, 16'd1, 8'h3C, 16'd0, 16'd0, 1'b0, 0, 0, 1'b0};
    load_cmd(abv);
    page = 1'b0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    cyc = 1; nw = 0; first_w = 0;
    while (cyc < 200 && nw < 2) begin
      if (w) begin
        nw++;
        if (nw == 1) first_w = cyc;
      end
      if (nw < 2) begin
        @(negedge clock);
        cyc++;
        if (cyc == 5) start = 1'b1;
        else if (cyc == 6) start = 1'b0;
      end
    end
    chk("abort_two_writes_seen", nw, 2);
    chk("abort_first_w_cycle", first_w, 44);
    @(posedge clock);
    #1 abort = 1'b1;
    #1 chk("abort_w_masked_now", w, 0);
    chk("abort_busy_until_edge", busy, 1);
    @(negedge clock);
    chk("abort_w_low", w, 0);
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy_low", busy, 0);
    chk("abort_no_done", done, 0);
    nd = 0; nw = 0;
    repeat (60) begin
      @(negedge clock);
      if (done) nd++;
      if (w) nw++;
    end
    chk("abort_no_late_done", nd, 0);
    chk("abort_no_late_write", nw, 0);
    chk("abort_err_kept", err, 0);

    // Start and abort together in idle: abort wins.
    @(negedge clock) begin start = 1'b1; abort = 1'b1; end
    @(negedge clock) begin start = 1'b0; abort = 1'b0; end
    chk("start_abort_idle_busy", busy, 0);

    // Asynchronous reset in the middle of a copy.
    load_cmd(vt[1]);
    page = 1'b1;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (49) @(negedge clock);
    chk("midcopy_busy", busy, 1);
    chk("midcopy_o", o, 8'h11);
    reset_n = 1'b0;
    #1;
    chk("rst_async_a", a, 0);
    chk("rst_async_o", o, 0);
    chk("rst_async_w", w, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_err", err, 0);
    @(negedge clock) reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_reset_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
